// File: rtl/quad_encoder_counter_pkg.sv
// Shared codes for the quadrature encoder counter: Gray phases, FSM states, direction values
// and the phase-to-phase move classifier.
package quad_encoder_counter_pkg;

   typedef enum logic [1:0] {
      PH_00 = 2'b00,
      PH_01 = 2'b01,
      PH_11 = 2'b11,
      PH_10 = 2'b10
   } phase_t;

   typedef enum logic {
      S_INIT = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      MV_NONE,
      MV_CW,
      MV_CCW,
      MV_ERR
   } move_t;

   localparam logic DIR_CW  = 1'b1;
   localparam logic DIR_CCW = 1'b0;

   // Position of an {A,B} code along the CW cycle 00->01->11->10.
   function automatic logic [1:0] phase_idx(input logic [1:0] ab);
      logic [1:0] idx;
      case (ab)
         PH_00:   idx = 2'd0;
         PH_01:   idx = 2'd1;
         PH_11:   idx = 2'd2;
         default: idx = 2'd3;
      endcase
      return idx;
   endfunction

   function automatic move_t classify(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
      logic [1:0] d;
      move_t      mv;
      d = phase_idx(cur_ab) - phase_idx(prev_ab);
      case (d)
         2'd0:    mv = MV_NONE;
         2'd1:    mv = MV_CW;
         2'd3:    mv = MV_CCW;
         default: mv = MV_ERR;
      endcase
      return mv;
   endfunction

endpackage

// File: rtl/quad_encoder_counter_enc_debounce.sv
// enc_debounce: 2-FF synchroniser, sample-tick divider and stability filter for the {A,B} pair.
// filt_vld pulses once each time a new stable value is accepted.
module enc_debounce #(
   parameter int SAMPLE_DIV = 2500,
   parameter int STABLE_CNT = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [1:0] raw_ab,
   output logic [1:0] filt_ab,
   output logic       filt_vld
);

   localparam int TW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
   localparam int SW = $clog2(STABLE_CNT + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
   localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE_CNT);

   logic [1:0]    sync1, sync2;
   logic [TW-1:0] tick_cnt;
   logic          tick;
   logic [1:0]    samp;
   logic [SW-1:0] stab, stab_nxt;
   logic          same, fire;

   assign tick = (tick_cnt == TICK_LAST);
   assign same = (sync2 == samp);

   always_comb begin
      stab_nxt = SW'(1);
      if (same)
         stab_nxt = (stab == STAB_MAX) ? stab : stab + SW'(1);
   end

   // Fire only on the tick where the run length first reaches the threshold.
   assign fire = tick && (stab_nxt == STAB_MAX) && (!same || stab != STAB_MAX);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync1    <= 2'b00;
         sync2    <= 2'b00;
         tick_cnt <= '0;
         samp     <= 2'b00;
         stab     <= '0;
         filt_ab  <= 2'b00;
         filt_vld <= 1'b0;
      end else begin
         sync1    <= raw_ab;
         sync2    <= sync1;
         tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
         filt_vld <= fire;
         if (tick) begin
            samp <= sync2;
            stab <= stab_nxt;
         end
         if (fire)
            filt_ab <= sync2;
      end
   end

endmodule

// File: rtl/quad_encoder_counter.sv
// Quadrature encoder up/down position counter with debounced inputs and illegal-jump flag.
// Optional build macro ENC_SATURATE_EN: COUNT saturates at 0 / max instead of wrapping.
module quad_encoder_counter
   import quad_encoder_counter_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int SAMPLE_DIV = 2500,
   parameter int STABLE_CNT = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ENC_A,
   input  logic             ENC_B,
   input  logic             CLR,
   output logic [WIDTH-1:0] COUNT,
   output logic             DIR,
   output logic             STEP,
   output logic             ERR
);

`ifdef ENC_SATURATE_EN
   localparam bit SATURATE = 1'b1;
`else
   localparam bit SATURATE = 1'b0;
`endif

   localparam logic [WIDTH-1:0] CNT_MAX = '1;

   logic [1:0]       filt_ab;
   logic             filt_vld;
   state_t           state_q, state_d;
   logic [1:0]       prev_q, prev_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             dir_q, dir_d;
   logic             step_d, err_d;
   move_t            mv;

   enc_debounce #(
      .SAMPLE_DIV (SAMPLE_DIV),
      .STABLE_CNT (STABLE_CNT)
   ) u_deb (
      .CLK      (CLK),
      .RST      (RST),
      .raw_ab   ({ENC_A, ENC_B}),
      .filt_ab  (filt_ab),
      .filt_vld (filt_vld)
   );

   assign mv = classify(prev_q, filt_ab);

   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      count_d = count_q;
      dir_d   = dir_q;
      step_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         S_INIT: begin
            if (filt_vld) begin
               prev_d  = filt_ab;
               state_d = S_RUN;
            end
         end
         default: begin
            if (filt_vld) begin
               prev_d = filt_ab;
               case (mv)
                  MV_CW: begin
                     dir_d = DIR_CW;
                     if (!(SATURATE && count_q == CNT_MAX)) begin
                        count_d = count_q + WIDTH'(1);
                        step_d  = 1'b1;
                     end
                  end
                  MV_CCW: begin
                     dir_d = DIR_CCW;
                     if (!(SATURATE && count_q == '0)) begin
                        count_d = count_q - WIDTH'(1);
                        step_d  = 1'b1;
                     end
                  end
                  MV_ERR:  err_d = 1'b1;
                  default: ;
               endcase
            end
         end
      endcase
      // Clear wins over a coincident step; phase tracking and DIR still follow the encoder.
      if (CLR) begin
         count_d = '0;
         step_d  = 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_INIT;
         prev_q  <= 2'b00;
         count_q <= '0;
         dir_q   <= DIR_CCW;
         STEP    <= 1'b0;
         ERR     <= 1'b0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         count_q <= count_d;
         dir_q   <= dir_d;
         STEP    <= step_d;
         ERR     <= err_d;
      end
   end

   assign COUNT = count_q;
   assign DIR   = dir_q;

endmodule

// File: tb/tb_quad_encoder_counter.sv
// Randomised self-checking bench for quad_encoder_counter (SAMPLE_DIV=4, STABLE_CNT=2).
// The model tracks encoder phase, count, direction and pulse totals at the step level.
module tb_quad_encoder_counter;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       ENC_A = 1'b0;
   logic       ENC_B = 1'b0;
   logic       CLR = 1'b0;
   logic [7:0] COUNT;
   logic       DIR, STEP, ERR;

   quad_encoder_counter #(.WIDTH(8), .SAMPLE_DIV(4), .STABLE_CNT(2)) dut (
      .CLK(CLK), .RST(RST), .ENC_A(ENC_A), .ENC_B(ENC_B), .CLR(CLR),
      .COUNT(COUNT), .DIR(DIR), .STEP(STEP), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

`ifdef ENC_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   int n_chk = 0, n_pass = 0;
   int step_seen = 0, err_seen = 0;
   int m_count = 0, m_dir = 0, m_ph = 0, m_steps = 0, m_errs = 0;
   logic [1:0] gray [4];
   logic [7:0] last_cnt = 8'd0;
   logic       rst_q = 1'b1, clr_q = 1'b0;

   task automatic check(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   // Per-cycle monitor: COUNT only moves by +-1 with STEP, or to 0 under CLR/RST.
   always @(posedge CLK) begin
      rst_q <= RST;
      clr_q <= CLR;
   end

   always @(negedge CLK) begin
      if (RST) begin
         check("rst_count", int'(COUNT), 0);
         check("rst_pulses", int'({STEP, ERR}), 0);
         last_cnt = 8'd0;
      end else begin
         if (STEP) step_seen++;
         if (ERR)  err_seen++;
         if (STEP && ERR) check("step_err_excl", 1, 0);
         if (!rst_q && !clr_q) begin
            if (STEP)
               check("step_delta", int'(COUNT == last_cnt + 8'd1 || COUNT == last_cnt - 8'd1), 1);
            else
               check("count_hold", int'(COUNT), int'(last_cnt));
         end
         last_cnt = COUNT;
      end
   end

   task automatic set_ph(input int p);
      {ENC_A, ENC_B} = gray[p];
   endtask

   task automatic settle_check(input string nm);
      repeat ($urandom_range(20, 26)) @(posedge CLK);
      #2;
      check({nm, "_count"}, int'(COUNT), m_count);
      check({nm, "_dir"},   int'(DIR),   m_dir);
      check({nm, "_steps"}, step_seen,   m_steps);
      check({nm, "_errs"},  err_seen,    m_errs);
   endtask

   // d is the phase offset mod 4: 1 = CW, 3 = CCW, 2 = illegal double jump.
   task automatic move(input int d, input bit with_clr, input string nm);
      @(posedge CLK); #1;
      if (with_clr) CLR = 1'b1;
      m_ph = (m_ph + d) % 4;
      set_ph(m_ph);
      if (d == 2) m_errs++;
      else begin
         m_dir = (d == 1);
         if (with_clr) m_count = 0;
         else if (SAT && d == 1 && m_count == 255) ;
         else if (SAT && d == 3 && m_count == 0) ;
         else begin
            m_count = (m_count + ((d == 1) ? 1 : 255)) % 256;
            m_steps++;
         end
      end
      if (with_clr) m_count = 0;
      settle_check(nm);
      if (with_clr) begin
         @(posedge CLK); #1;
         CLR = 1'b0;
      end
   endtask

   task automatic drive_to(input int target);
      for (int k = 0; k < 600 && m_count != target; k++) begin
         if (SAT) move((target > m_count) ? 1 : 3, 1'b0, "drive");
         else     move((((target - m_count) % 256 + 256) % 256 <= 128) ? 1 : 3, 1'b0, "drive");
      end
      check("drive_reach", m_count, target);
   endtask

   task automatic glitch(input bit on_a, input int len);
      @(posedge CLK); #1;
      if (on_a) ENC_A = ~ENC_A; else ENC_B = ~ENC_B;
      repeat (len) @(posedge CLK);
      #1;
      set_ph(m_ph);
   endtask

   task automatic do_reset(input int ph);
      @(posedge CLK); #1;
      RST = 1'b1;
      m_ph = ph;
      set_ph(ph);
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b0;
      step_seen = 0; err_seen = 0;
      m_count = 0; m_dir = 0; m_steps = 0; m_errs = 0;
   endtask

   initial begin
      int r;
      gray[0] = 2'b00; gray[1] = 2'b01; gray[2] = 2'b11; gray[3] = 2'b10;

      // Release reset holding 11: S_INIT absorbs it silently.
      ENC_A = 1'b1; ENC_B = 1'b1;
      do_reset(2);
      settle_check("rst11");
      check("rst11_lit", int'(COUNT), 0);

      do_reset(0);
      settle_check("rst00");

      for (int i = 0; i < 8; i++) move(1, 1'b0, "cw");
      check("cw8_lit", int'(COUNT), 8);
      check("cw8_dir_lit", int'(DIR), 1);
      check("cw8_steps_lit", step_seen, 8);
      for (int i = 0; i < 3; i++) move(3, 1'b0, "ccw");
      check("ccw3_lit", int'(COUNT), 5);
      check("ccw3_dir_lit", int'(DIR), 0);

      move(3, 1'b0, "to00");
      glitch(1'b1, 3);
      settle_check("glitch_a");
      move(1, 1'b0, "hold_b");
      check("hold_b_lit", int'(COUNT), 5);

      move(3, 1'b0, "back00");
      move(2, 1'b0, "err0011");
      check("err_lit", err_seen, 1);
      check("err_count_lit", int'(COUNT), 4);
      move(1, 1'b0, "after_err");
      check("after_err_lit", int'(COUNT), 5);

`ifdef ENC_SATURATE_EN
      drive_to(255);
      move(1, 1'b0, "sat_hi");
      check("sat_hi_lit", int'(COUNT), 255);
      drive_to(0);
      move(3, 1'b0, "sat_lo");
      check("sat_lo_lit", int'(COUNT), 0);
`else
      drive_to(0);
      move(3, 1'b0, "wrap_lo");
      check("wrap_lo_lit", int'(COUNT), 255);
      move(1, 1'b0, "wrap_hi");
      check("wrap_hi_lit", int'(COUNT), 0);
`endif

      drive_to(3);
      move(1, 1'b1, "clr_step");
      check("clr_lit", int'(COUNT), 0);
      move(1, 1'b0, "post_clr");
      check("post_clr_lit", int'(COUNT), 1);

      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 9);
         if ($urandom_range(0, 3) == 0) glitch($urandom_range(0, 1) == 1, $urandom_range(1, 3));
         if (r < 4)       move(1, 1'b0, "rnd_cw");
         else if (r < 8)  move(3, 1'b0, "rnd_ccw");
         else if (r == 8) move(2, 1'b0, "rnd_err");
         else             settle_check("rnd_glitch");
      end

      drive_to(37);
      check("pre_rst_count", int'(COUNT), 37);
      @(posedge CLK); #3;
      RST = 1'b1;
      #1;
      check("async_rst_count", int'(COUNT), 0);
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      repeat (4) @(posedge CLK);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
